obi_l1_responder: RTL and testbench

- OBI subordinate (responder) for one L1 SRAM bank; serves the OBI initiator requests issued by the tile iDMA transfer channels and the core data port.
- Accepts requests with a credit-limited req/gnt handshake and drives a fixed-latency single-port SRAM macro.
- Returns in-order responses through a response FIFO with rvalid/rready backpressure; flags out-of-range accesses as errors without touching the SRAM.

---
 rtl/obi_l1_responder.sv | 168 ++++++++++++++++
 tb/tb_obi_l1_responder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_l1_responder.sv
// OBI responder for one L1 SRAM bank: credit-limited req/gnt, fixed-latency SRAM, in-order response FIFO.
// Latency: SRAM access in the grant cycle, response visible SRAM_LAT+1 cycles after acceptance.
// Backpressure: rready_i low stalls the FIFO head; grants stop once MAX_OUTSTANDING requests are unreturned.
module obi_l1_responder #(
  parameter int unsigned        ADDR_W          = 32,
  parameter int unsigned        DATA_W          = 32,
  parameter int unsigned        ID_W            = 4,
  parameter logic [ADDR_W-1:0]  BASE_ADDR       = 32'h1000_0000,
  parameter int unsigned        SIZE_BYTES      = 65536,
  parameter int unsigned        SRAM_LAT        = 1,
  parameter int unsigned        MAX_OUTSTANDING = 4,
  localparam int unsigned       BE_W            = DATA_W / 8,
  localparam int unsigned       SRAM_AW         = $clog2(SIZE_BYTES / BE_W)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                req_i,
  output logic                gnt_o,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                we_i,
  input  logic [BE_W-1:0]     be_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [ID_W-1:0]     aid_i,
  output logic                rvalid_o,
  input  logic                rready_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [ID_W-1:0]     rid_o,
  output logic                err_o,
  output logic                sram_req_o,
  output logic                sram_we_o,
  output logic [SRAM_AW-1:0]  sram_addr_o,
  output logic [BE_W-1:0]     sram_be_o,
  output logic [DATA_W-1:0]   sram_wdata_o,
  input  logic [DATA_W-1:0]   sram_rdata_i,
  output logic                busy_o
);

  localparam int unsigned      OFF_W   = $clog2(BE_W);
  localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned      PTR_W   = $clog2(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  // One bit wider than the address so BASE_ADDR + SIZE_BYTES cannot wrap.
  localparam logic [ADDR_W:0]  LIMIT   = {1'b0, BASE_ADDR} + (ADDR_W + 1)'(SIZE_BYTES);

  logic [CNT_W-1:0]   count_q;
  logic               accept;
  logic               pop;
  logic               push;
  logic               in_range;
  logic [ADDR_W-1:0]  offset;
  logic [DATA_W-1:0]  push_data;

  logic [SRAM_LAT-1:0] pipe_vld;
  logic [SRAM_LAT-1:0] pipe_we;
  logic [SRAM_LAT-1:0] pipe_err;
  logic [ID_W-1:0]     pipe_id [SRAM_LAT];

  logic [DATA_W-1:0]          fifo_data [MAX_OUTSTANDING];
  logic [ID_W-1:0]            fifo_id   [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] fifo_err;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           fill;
  logic                       fifo_full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Request side: credit check on the registered count only; reset also masks the grant.
  assign in_range = ({1'b0, addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, addr_i} < LIMIT);
  assign gnt_o    = req_i & (count_q < MAX_CNT) & ~clear_i & ~rst_i;
  assign accept   = req_i & gnt_o;
  assign offset   = addr_i - BASE_ADDR;

  // SRAM is only strobed for in-range accesses; the rest passes straight through.
  assign sram_req_o   = accept & in_range;
  assign sram_we_o    = we_i;
  assign sram_addr_o  = SRAM_AW'(offset >> OFF_W);
  assign sram_be_o    = be_i;
  assign sram_wdata_o = wdata_i;

  // Response side: FIFO head drives the outputs, zeroed when nothing is valid.
  assign rvalid_o  = (fill != '0);
  assign rdata_o   = rvalid_o ? fifo_data[rd_ptr] : '0;
  assign rid_o     = rvalid_o ? fifo_id[rd_ptr]   : '0;
  assign err_o     = rvalid_o ? fifo_err[rd_ptr]  : 1'b0;
  assign pop       = rvalid_o & rready_i;
  assign fifo_full = (fill == MAX_CNT);
  assign busy_o    = (count_q != '0);

  // Last pipeline stage lines up with the SRAM read data; writes and errors return zero.
  assign push      = pipe_vld[SRAM_LAT-1];
  assign push_data = (pipe_we[SRAM_LAT-1] | pipe_err[SRAM_LAT-1]) ? '0 : sram_rdata_i;

  // Outstanding-request counter: accepted but not yet popped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Latency pipeline tracking request attributes while the SRAM produces read data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld <= '0;
      pipe_we  <= '0;
      pipe_err <= '0;
      for (int i = 0; i < SRAM_LAT; i++) pipe_id[i] <= '0;
    end else if (clear_i) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept;
      pipe_we[0]  <= we_i;
      pipe_err[0] <= ~in_range;
      pipe_id[0]  <= aid_i;
      for (int i = 1; i < SRAM_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_we[i]  <= pipe_we[i-1];
        pipe_err[i] <= pipe_err[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  // FIFO storage; contents need no reset since outputs are gated by fill.
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_id[wr_ptr]   <= pipe_id[SRAM_LAT-1];
      fifo_err[wr_ptr]  <= pipe_err[SRAM_LAT-1];
    end
  end

  // FIFO pointers and fill level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fill <= fill + CNT_W'(1);
        2'b01:   fill <= fill - CNT_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  // The credit limit guarantees the FIFO never overflows.
  assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full));

endmodule

// File: tb/tb_obi_l1_responder.sv
module tb_obi_l1_responder;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          SIZE  = 65536;
  localparam int          WORDS = SIZE / 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        clear_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic        rready_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  be_i = '0;
  logic [3:0]  aid_i = '0;
  logic [31:0] sram_rdata_i = '0;
  logic        gnt_o, rvalid_o, err_o, sram_req_o, sram_we_o, busy_o;
  logic [31:0] rdata_o, sram_wdata_o;
  logic [3:0]  rid_o, sram_be_o;
  logic [13:0] sram_addr_o;

  obi_l1_responder #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4), .BASE_ADDR(32'h1000_0000),
    .SIZE_BYTES(65536), .SRAM_LAT(1), .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .aid_i(aid_i),
    .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rid_o(rid_o), .err_o(err_o),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_be_o(sram_be_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SRAM macro model, one cycle read latency; garbage on the data bus otherwise.
  logic [31:0] smem [WORDS];
  logic [31:0] sword;
  always @(posedge clk_i) begin
    if (sram_req_o && !sram_we_o) begin
      sram_rdata_i <= smem[sram_addr_o];
    end else begin
      sram_rdata_i <= $urandom();
      if (sram_req_o) begin
        sword = smem[sram_addr_o];
        for (int b = 0; b < 4; b++)
          if (sram_be_o[b]) sword[8*b +: 8] = sram_wdata_o[8*b +: 8];
        smem[sram_addr_o] = sword;
      end
    end
  end

  // Reference model: shadow memory plus a queue of expected responses in acceptance order.
  typedef struct {
    logic [3:0]  id;
    logic        err;
    logic [31:0] data;
    int          rdy;
  } exp_t;

  logic [31:0] shadow [WORDS];
  exp_t        q[$];
  exp_t        e;
  int          cyc = 0;
  int          n_resp = 0;
  int          idx;
  longint      a;
  logic        exp_rvalid, exp_gnt, inr;
  logic [31:0] w;
  logic [31:0] last_rdata = '0;
  logic [3:0]  last_rid = '0;
  logic        last_err = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (rst_i) begin
      q.delete();
    end else begin
      exp_gnt = req_i && (q.size() < 4) && !clear_i;
      chk("gnt", gnt_o, exp_gnt);
      chk("busy", busy_o, q.size() != 0);
      exp_rvalid = 1'b0;
      if (q.size() > 0) exp_rvalid = (q[0].rdy <= cyc);
      chk("rvalid", rvalid_o, exp_rvalid);
      if (exp_rvalid && rvalid_o) begin
        chk("rid", rid_o, q[0].id);
        chk("err", err_o, q[0].err);
        chk("rdata", rdata_o, q[0].data);
        if (rready_i) begin
          last_rdata = rdata_o;
          last_rid   = rid_o;
          last_err   = err_o;
          n_resp++;
          void'(q.pop_front());
        end
      end
      a   = longint'(addr_i);
      inr = (a >= longint'(BASE)) && (a < longint'(BASE) + SIZE);
      chk("sram_req", sram_req_o, req_i && gnt_o && inr);
      if (clear_i) begin
        q.delete();
      end else if (req_i && gnt_o) begin
        e.id   = aid_i;
        e.rdy  = cyc + 2;
        e.err  = !inr;
        e.data = '0;
        if (inr) begin
          idx = int'((a - longint'(BASE)) >> 2);
          chk("sram_addr", sram_addr_o, idx);
          chk("sram_we", sram_we_o, we_i);
          if (we_i) begin
            chk("sram_be", sram_be_o, be_i);
            chk("sram_wdata", sram_wdata_o, wdata_i);
            w = shadow[idx];
            for (int b = 0; b < 4; b++)
              if (be_i[b]) w[8*b +: 8] = wdata_i[8*b +: 8];
            shadow[idx] = w;
          end else begin
            e.data = shadow[idx];
          end
        end
        q.push_back(e);
      end
    end
  end

  task automatic issue(input logic [31:0] ad, input logic wr, input logic [3:0] b,
                       input logic [31:0] d, input logic [3:0] id);
    logic granted;
    granted = 1'b0;
    req_i = 1'b1; addr_i = ad; we_i = wr; be_i = b; wdata_i = d; aid_i = id;
    for (int k = 0; k < 50 && !granted; k++) begin
      @(negedge clk_i);
      granted = gnt_o;
      @(posedge clk_i); #1;
      if (!granted) rready_i = 1'b1;
    end
    req_i = 1'b0;
    chk("issue_granted", granted, 1'b1);
  endtask

  task automatic drain();
    rready_i = 1'b1;
    for (int k = 0; k < 60 && q.size() != 0; k++) begin
      @(posedge clk_i); #1;
    end
    chk("drain_pending", q.size(), 0);
    chk("drain_busy", busy_o, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ngr, waitc, c0, nbefore;
    logic        gr;
    logic [31:0] ra;
    int          sel;

    for (int i = 0; i < WORDS; i++) begin
      smem[i]   = $urandom();
      shadow[i] = smem[i];
    end
    smem[4] = 32'hDEAD_BEEF; shadow[4] = 32'hDEAD_BEEF;
    smem[8] = 32'h1122_3344; shadow[8] = 32'h1122_3344;

    // Reset state, with a request pending to prove the grant is masked.
    rst_i = 1'b1; req_i = 1'b1; addr_i = BASE;
    @(posedge clk_i); #1;
    chk("rst_gnt", gnt_o, 1'b0);
    chk("rst_rvalid", rvalid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_sram_req", sram_req_o, 1'b0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_rid", rid_o, 4'h0);
    chk("rst_err", err_o, 1'b0);
    req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0; rready_i = 1'b1;
    @(posedge clk_i); #1;

    // Single read.
    issue(BASE + 32'h10, 1'b0, 4'hF, 32'h0, 4'd3);
    drain();
    chk("rd_data", last_rdata, 32'hDEAD_BEEF);
    chk("rd_rid", last_rid, 4'd3);
    chk("rd_err", last_err, 1'b0);

    // Partial write, then read back the merged word.
    issue(BASE + 32'h20, 1'b1, 4'b0101, 32'hAABB_CCDD, 4'd5);
    drain();
    chk("wr_rdata", last_rdata, 32'h0);
    chk("wr_err", last_err, 1'b0);
    issue(BASE + 32'h20, 1'b0, 4'hF, 32'h0, 4'd6);
    drain();
    chk("wr_readback", last_rdata, 32'h11BB_33DD);

    // Out of range behind a read, and both range edges.
    issue(BASE + 32'h10, 1'b0, 4'hF, 32'h0, 4'd2);
    issue(BASE + SIZE, 1'b0, 4'hF, 32'h0, 4'd7);
    drain();
    chk("oor_rid", last_rid, 4'd7);
    chk("oor_err", last_err, 1'b1);
    chk("oor_rdata", last_rdata, 32'h0);
    issue(BASE + SIZE - 4, 1'b0, 4'hF, 32'h0, 4'd8);
    drain();
    chk("top_word_err", last_err, 1'b0);
    issue(BASE - 4, 1'b0, 4'hF, 32'h0, 4'd9);
    drain();
    chk("below_base_err", last_err, 1'b1);

    // Backpressure: request held for 8 cycles with rready low.
    rready_i = 1'b0; req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = BASE + 32'h40;
    ngr = 0;
    for (int k = 0; k < 8; k++) begin
      aid_i = 4'(k);
      @(negedge clk_i);
      if (gnt_o) ngr++;
      @(posedge clk_i); #1;
    end
    chk("bp_grants", ngr, 4);
    chk("bp_busy", busy_o, 1'b1);
    chk("bp_rvalid", rvalid_o, 1'b1);
    aid_i = 4'd8; rready_i = 1'b1; waitc = 0; gr = 1'b0;
    for (int k = 0; k < 20 && !gr; k++) begin
      @(negedge clk_i);
      if (gnt_o) gr = 1'b1; else waitc++;
      @(posedge clk_i); #1;
    end
    req_i = 1'b0;
    chk("bp_regrant_delay", waitc, 1);
    drain();

    // Streaming: 16 back-to-back reads.
    rready_i = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 16; k++)
      issue(BASE + (32'($urandom_range(0, WORDS - 1)) << 2), 1'b0, 4'hF, 32'h0, 4'(k));
    chk("stream_cycles", cyc - c0, 16);
    drain();

    // Random mix of reads, writes and errors with random backpressure.
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       ra = BASE - 32'(4 * $urandom_range(1, 4));
        1:       ra = BASE + SIZE + 32'($urandom_range(0, 255));
        2:       ra = BASE + SIZE - 4 + 32'($urandom_range(0, 3));
        default: ra = BASE + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
      endcase
      rready_i = ($urandom_range(0, 3) != 0);
      issue(ra, 1'($urandom_range(0, 1)), 4'($urandom()), $urandom(), 4'($urandom()));
    end
    drain();

    // Synchronous clear with three responses in flight.
    rready_i = 1'b0;
    issue(BASE + 32'h10, 1'b0, 4'hF, 32'h0, 4'd1);
    issue(BASE + 32'h14, 1'b0, 4'hF, 32'h0, 4'd2);
    issue(BASE + 32'h18, 1'b0, 4'hF, 32'h0, 4'd3);
    nbefore = n_resp;
    clear_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    chk("clr_rvalid", rvalid_o, 1'b0);
    chk("clr_busy", busy_o, 1'b0);
    rready_i = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
    chk("clr_no_stale", n_resp, nbefore);

    // Asynchronous reset mid-stream, asserted between clock edges.
    rready_i = 1'b0;
    issue(BASE + 32'h10, 1'b0, 4'hF, 32'h0, 4'd4);
    issue(BASE + 32'h14, 1'b0, 4'hF, 32'h0, 4'd5);
    issue(BASE + 32'h18, 1'b0, 4'hF, 32'h0, 4'd6);
    chk("pre_rst_rvalid", rvalid_o, 1'b1);
    req_i = 1'b1; addr_i = BASE;
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_gnt", gnt_o, 1'b0);
    chk("arst_rvalid", rvalid_o, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_sram_req", sram_req_o, 1'b0);
    chk("arst_rdata", rdata_o, 32'h0);
    chk("arst_rid", rid_o, 4'h0);
    @(posedge clk_i); #1;
    req_i = 1'b0; rst_i = 1'b0;
    nbefore = n_resp;
    rready_i = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
    chk("arst_no_stale", n_resp, nbefore);

    // Still functional after the reset.
    issue(BASE + 32'h10, 1'b0, 4'hF, 32'h0, 4'd11);
    drain();
    chk("post_rst_rid", last_rid, 4'd11);
    chk("post_rst_rdata", last_rdata, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
